// File: rtl/tcp_rx_msg_poller.sv
// Pending-request poller: queues "notify me when N bytes are ready on flow F" requests and
// round-robins over them, reading each flow's head/commit pointers until enough bytes exist.
module tcp_rx_msg_poller #(
    parameter int FLOWID_W         = 8,
    parameter int RX_PAYLOAD_PTR_W = 16,
    parameter int DST_X_W          = 4,
    parameter int DST_Y_W          = 4,
    parameter int DST_FBITS_W      = 4,
    parameter int PEND_DEPTH       = 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          noc_if_poller_msg_req_val,
    input  logic [FLOWID_W-1:0]           noc_if_poller_msg_req_flowid,
    input  logic [RX_PAYLOAD_PTR_W-1:0]   noc_if_poller_msg_req_len,
    input  logic [DST_X_W-1:0]            noc_if_poller_msg_dst_x,
    input  logic [DST_Y_W-1:0]            noc_if_poller_msg_dst_y,
    input  logic [DST_FBITS_W-1:0]        noc_if_poller_msg_dst_fbits,
    output logic                          poller_noc_if_msg_req_rdy,

    output logic                          poller_head_ptr_rd_req_val,
    output logic [FLOWID_W-1:0]           poller_head_ptr_rd_req_addr,
    input  logic                          head_ptr_poller_rd_req_rdy,
    input  logic                          head_ptr_poller_rd_resp_val,
    input  logic [RX_PAYLOAD_PTR_W:0]     head_ptr_poller_rd_resp_data,

    output logic                          poller_commit_ptr_rd_req_val,
    output logic [FLOWID_W-1:0]           poller_commit_ptr_rd_req_addr,
    input  logic                          commit_ptr_poller_rd_req_rdy,
    input  logic                          commit_ptr_poller_rd_resp_val,
    input  logic [RX_PAYLOAD_PTR_W:0]     commit_ptr_poller_rd_resp_data,

    output logic                          poller_msg_noc_if_out_val,
    output logic [FLOWID_W-1:0]           poller_msg_noc_if_out_flowid,
    output logic [RX_PAYLOAD_PTR_W:0]     poller_msg_noc_if_out_head_ptr,
    output logic [RX_PAYLOAD_PTR_W-1:0]   poller_msg_noc_if_out_len,
    output logic [DST_X_W-1:0]            poller_msg_noc_if_out_dst_x,
    output logic [DST_Y_W-1:0]            poller_msg_noc_if_out_dst_y,
    output logic [DST_FBITS_W-1:0]        poller_msg_noc_if_out_dst_fbits,
    input  logic                          noc_if_out_poller_msg_rdy,

    output logic [2:0]                    o_dbg_state
);

    localparam int PTR_W = RX_PAYLOAD_PTR_W + 1;
    localparam int IDX_W = $clog2(PEND_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(PEND_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_SEND    = 3'd4,
        ST_REQUEUE = 3'd5
    } state_t;

    typedef struct packed {
        logic [FLOWID_W-1:0]         flowid;
        logic [RX_PAYLOAD_PTR_W-1:0] len;
        logic [DST_X_W-1:0]          dst_x;
        logic [DST_Y_W-1:0]          dst_y;
        logic [DST_FBITS_W-1:0]      dst_fbits;
    } entry_t;

    // Every handshake (request in, pointer reads, notification out) transfers on the
    // cycle where val && rdy at the rising edge; a val, once raised, holds its payload until then.

    entry_t           r_mem [PEND_DEPTH];
    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;

    state_t           r_state;
    entry_t           r_work;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_commit;
    logic             r_head_vld;
    logic             r_commit_vld;
    logic             r_head_req_val;
    logic             r_commit_req_val;
    logic             r_out_val;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_occupancy;
    logic             w_inflight;
    logic             w_requeue;
    logic             w_up_fire;
    logic             w_wr_en;
    logic             w_pop;
    entry_t           w_up_entry;
    entry_t           w_wr_entry;
    entry_t           w_rd_entry;
    logic             w_head_take;
    logic             w_commit_take;
    logic             w_head_have;
    logic             w_commit_have;
    logic [PTR_W-1:0] w_avail;
    logic             w_sat;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_inflight  = (r_state != ST_IDLE);
    assign w_requeue   = (r_state == ST_REQUEUE);
    assign w_occupancy = {1'b0, w_count} + (CNT_W + 1)'(w_inflight);

    // Counting the in-flight entry reserves a slot for it, so a requeue always finds room.
    assign poller_noc_if_msg_req_rdy = (w_occupancy < DEPTH_C) && !w_requeue;

    assign w_up_fire  = noc_if_poller_msg_req_val && poller_noc_if_msg_req_rdy;
    assign w_wr_en    = w_up_fire || w_requeue;
    assign w_pop      = (r_state == ST_IDLE) && (w_count != '0);

    assign w_up_entry.flowid    = noc_if_poller_msg_req_flowid;
    assign w_up_entry.len       = noc_if_poller_msg_req_len;
    assign w_up_entry.dst_x     = noc_if_poller_msg_dst_x;
    assign w_up_entry.dst_y     = noc_if_poller_msg_dst_y;
    assign w_up_entry.dst_fbits = noc_if_poller_msg_dst_fbits;

    assign w_wr_entry = w_requeue ? r_work : w_up_entry;
    assign w_rd_entry = r_mem[r_rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // A response only counts once its own request was accepted, so stale data cannot be taken.
    assign w_head_take   = head_ptr_poller_rd_resp_val && !r_head_req_val && !r_head_vld;
    assign w_commit_take = commit_ptr_poller_rd_resp_val && !r_commit_req_val && !r_commit_vld;
    assign w_head_have   = r_head_vld || w_head_take;
    assign w_commit_have = r_commit_vld || w_commit_take;

    // Extra wrap bit makes the modular difference correct across buffer wrap.
    assign w_avail = r_commit - r_head;
    assign w_sat   = (w_avail >= {1'b0, r_work.len});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_work           <= '0;
            r_head           <= '0;
            r_commit         <= '0;
            r_head_vld       <= 1'b0;
            r_commit_vld     <= 1'b0;
            r_head_req_val   <= 1'b0;
            r_commit_req_val <= 1'b0;
            r_out_val        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_work           <= w_rd_entry;
                        r_head_vld       <= 1'b0;
                        r_commit_vld     <= 1'b0;
                        r_head_req_val   <= 1'b1;
                        r_commit_req_val <= 1'b1;
                        r_state          <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ, ST_RD_WAIT: begin
                    if (r_head_req_val && head_ptr_poller_rd_req_rdy) r_head_req_val <= 1'b0;
                    if (r_commit_req_val && commit_ptr_poller_rd_req_rdy) r_commit_req_val <= 1'b0;
                    if (w_head_take) begin
                        r_head     <= head_ptr_poller_rd_resp_data;
                        r_head_vld <= 1'b1;
                    end
                    if (w_commit_take) begin
                        r_commit     <= commit_ptr_poller_rd_resp_data;
                        r_commit_vld <= 1'b1;
                    end
                    if (r_state == ST_RD_REQ) begin
                        if ((!r_head_req_val || head_ptr_poller_rd_req_rdy) &&
                            (!r_commit_req_val || commit_ptr_poller_rd_req_rdy)) begin
                            r_state <= ST_RD_WAIT;
                        end
                    end else if (w_head_have && w_commit_have) begin
                        r_state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (w_sat) begin
                        r_out_val <= 1'b1;
                        r_state   <= ST_SEND;
                    end else begin
                        r_state   <= ST_REQUEUE;
                    end
                end
                ST_SEND: begin
                    if (noc_if_out_poller_msg_rdy) begin
                        r_out_val <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_REQUEUE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign poller_head_ptr_rd_req_val      = r_head_req_val;
    assign poller_head_ptr_rd_req_addr     = r_work.flowid;
    assign poller_commit_ptr_rd_req_val    = r_commit_req_val;
    assign poller_commit_ptr_rd_req_addr   = r_work.flowid;

    assign poller_msg_noc_if_out_val       = r_out_val;
    assign poller_msg_noc_if_out_flowid    = r_work.flowid;
    assign poller_msg_noc_if_out_head_ptr  = r_head;
    assign poller_msg_noc_if_out_len       = r_work.len;
    assign poller_msg_noc_if_out_dst_x     = r_work.dst_x;
    assign poller_msg_noc_if_out_dst_y     = r_work.dst_y;
    assign poller_msg_noc_if_out_dst_fbits = r_work.dst_fbits;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tcp_rx_msg_poller.sv
// Bench for tcp_rx_msg_poller: pointer-memory responders, a notification monitor,
// directed vector table, multi-cycle corner sequences and a randomized scoreboard run.
module tb_tcp_rx_msg_poller;

    localparam int NW = 8 + 17 + 16 + 4 + 4 + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_val = 1'b0;
    logic [7:0]  req_flowid = '0;
    logic [15:0] req_len = '0;
    logic [3:0]  req_x = '0, req_y = '0, req_b = '0;
    logic        req_rdy;
    logic        h_req_val, c_req_val;
    logic [7:0]  h_req_addr, c_req_addr;
    logic        h_req_rdy = 1'b1, c_req_rdy = 1'b1;
    logic        h_resp_val = 1'b0, c_resp_val = 1'b0;
    logic [16:0] h_resp_data = '0, c_resp_data = '0;
    logic        out_val;
    logic [7:0]  out_flowid;
    logic [16:0] out_head;
    logic [15:0] out_len;
    logic [3:0]  out_x, out_y, out_b;
    logic        out_rdy = 1'b1;
    logic [2:0]  dbg_state;

    tcp_rx_msg_poller dut (
        .clk(clk), .rst(rst),
        .noc_if_poller_msg_req_val(req_val),
        .noc_if_poller_msg_req_flowid(req_flowid),
        .noc_if_poller_msg_req_len(req_len),
        .noc_if_poller_msg_dst_x(req_x),
        .noc_if_poller_msg_dst_y(req_y),
        .noc_if_poller_msg_dst_fbits(req_b),
        .poller_noc_if_msg_req_rdy(req_rdy),
        .poller_head_ptr_rd_req_val(h_req_val),
        .poller_head_ptr_rd_req_addr(h_req_addr),
        .head_ptr_poller_rd_req_rdy(h_req_rdy),
        .head_ptr_poller_rd_resp_val(h_resp_val),
        .head_ptr_poller_rd_resp_data(h_resp_data),
        .poller_commit_ptr_rd_req_val(c_req_val),
        .poller_commit_ptr_rd_req_addr(c_req_addr),
        .commit_ptr_poller_rd_req_rdy(c_req_rdy),
        .commit_ptr_poller_rd_resp_val(c_resp_val),
        .commit_ptr_poller_rd_resp_data(c_resp_data),
        .poller_msg_noc_if_out_val(out_val),
        .poller_msg_noc_if_out_flowid(out_flowid),
        .poller_msg_noc_if_out_head_ptr(out_head),
        .poller_msg_noc_if_out_len(out_len),
        .poller_msg_noc_if_out_dst_x(out_x),
        .poller_msg_noc_if_out_dst_y(out_y),
        .poller_msg_noc_if_out_dst_fbits(out_b),
        .noc_if_out_poller_msg_rdy(out_rdy),
        .o_dbg_state(dbg_state)
    );

    // Pointer memories and their responders (not reset: late responses must still appear).
    logic [16:0] head_mem [256];
    logic [16:0] commit_mem [256];
    bit          mem_rand = 1'b0;
    int          h_delay = 0, c_delay = 0;
    bit          h_busy = 1'b0, c_busy = 1'b0;
    int          h_cnt = 0, c_cnt = 0;
    logic [7:0]  h_addr = '0, c_addr = '0;

    always @(posedge clk) begin
        #1;
        h_resp_val = 1'b0;
        if (h_busy) begin
            if (h_cnt == 0) begin
                h_resp_val  = 1'b1;
                h_resp_data = head_mem[h_addr];
                h_busy      = 1'b0;
            end else h_cnt--;
        end
        h_req_rdy = !h_busy && (mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (h_req_val && h_req_rdy) begin
            h_busy = 1'b1;
            h_addr = h_req_addr;
            h_cnt  = mem_rand ? int'($urandom_range(0, 3)) : h_delay;
        end
    end

    always @(posedge clk) begin
        #1;
        c_resp_val = 1'b0;
        if (c_busy) begin
            if (c_cnt == 0) begin
                c_resp_val  = 1'b1;
                c_resp_data = commit_mem[c_addr];
                c_busy      = 1'b0;
            end else c_cnt--;
        end
        c_req_rdy = !c_busy && (mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (c_req_val && c_req_rdy) begin
            c_busy = 1'b1;
            c_addr = c_req_addr;
            c_cnt  = mem_rand ? int'($urandom_range(0, 3)) : c_delay;
        end
    end

    int out_mode = 1;  // 0 hold low, 1 always ready, 2 random
    always @(posedge clk) begin
        #1;
        case (out_mode)
            0:       out_rdy = 1'b0;
            1:       out_rdy = 1'b1;
            default: out_rdy = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: records every accepted notification and watches stalled outputs for stability.
    logic [NW-1:0] obs_q[$];
    logic [NW-1:0] w_obs;
    logic [NW-1:0] snap = '0;
    bit            stalled = 1'b0;
    int            stab_viol = 0, stab_checks = 0;
    assign w_obs = {out_flowid, out_head, out_len, out_x, out_y, out_b};

    always @(negedge clk) begin
        if (rst) stalled = 1'b0;
        else begin
            if (stalled) begin
                stab_checks++;
                if (!out_val || w_obs != snap) stab_viol++;
            end
            if (out_val && out_rdy) obs_q.push_back(w_obs);
            stalled = out_val && !out_rdy;
            snap    = w_obs;
        end
    end

    int            checks = 0, failures = 0;
    int            obs_rd = 0;
    int            hs_cyc = 0;
    logic [NW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NW-1:0] mk(input logic [7:0] f, input logic [16:0] h,
                                         input logic [15:0] l, input logic [3:0] x,
                                         input logic [3:0] y, input logic [3:0] b);
        return {f, h, l, x, y, b};
    endfunction

    task automatic send_req(input logic [7:0] f, input logic [15:0] l, input logic [3:0] x,
                            input logic [3:0] y, input logic [3:0] b);
        bit ok;
        @(posedge clk); #1;
        req_val = 1'b1; req_flowid = f; req_len = l; req_x = x; req_y = y; req_b = b;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (req_rdy) begin
                @(posedge clk); #1;
                hs_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        chk("req_accepted", 64'(ok), 64'd1);
    endtask

    task automatic next_obs(input int budget, output logic [NW-1:0] o, output bit ok);
        ok = 1'b0;
        o  = '0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() > obs_rd) begin
                o = obs_q[obs_rd];
                obs_rd++;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name, input int budget, input bit ordered);
        logic [NW-1:0] o;
        bit            ok;
        int            idx;
        while (exp_q.size() > 0) begin
            next_obs(budget, o, ok);
            if (!ok) begin
                chk({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
                exp_q.delete();
            end else begin
                idx = 0;
                if (!ordered) begin
                    foreach (exp_q[k]) if (exp_q[k] == o) idx = k;
                end
                chk(name, 64'(o), 64'(exp_q[idx]));
                exp_q.delete(idx);
            end
        end
    endtask

    task automatic expect_quiet(input string name, input int n);
        repeat (n) @(negedge clk);
        chk(name, 64'(obs_q.size() - obs_rd), 64'd0);
        obs_rd = obs_q.size();
    endtask

    typedef struct {
        logic [7:0]  f;
        logic [15:0] len;
        logic [16:0] head;
        logic [16:0] commit;
        bit          sat;
    } vec_t;
    vec_t vecs[9];

    logic [16:0] av;
    logic [16:0] raise;
    logic [15:0] len;
    logic [7:0]  f;
    logic [3:0]  x, y, b;
    int          lat, hi, n_unsat, cand;
    bit          found, sat;
    logic [NW-1:0] unsat_q[$];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd3,  16'd64,    17'h00010, 17'h00060, 1'b1};
        vecs[1] = '{8'd5,  16'd100,   17'h00000, 17'h00032, 1'b0};
        vecs[2] = '{8'd7,  16'd32,    17'h1FFF0, 17'h00010, 1'b1};
        vecs[3] = '{8'd7,  16'd33,    17'h1FFF0, 17'h00010, 1'b0};
        vecs[4] = '{8'd9,  16'd0,     17'h00123, 17'h00123, 1'b1};
        vecs[5] = '{8'd10, 16'd1,     17'h00123, 17'h00123, 1'b0};
        vecs[6] = '{8'd11, 16'h8000,  17'h10000, 17'h18000, 1'b1};
        vecs[7] = '{8'd12, 16'hFFFF,  17'h00005, 17'h10004, 1'b1};
        vecs[8] = '{8'd13, 16'hFFFF,  17'h00005, 17'h10003, 1'b0};

        // Reset state
        #1;
        chk("rst_vals", 64'({h_req_val, c_req_val, out_val}), 64'd0);
        chk("rst_data", 64'(w_obs), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rdy_after_rst", 64'(req_rdy), 64'd1);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            x = 4'(i + 1); y = 4'(15 - i); b = 4'(i ^ 5);
            head_mem[vecs[i].f]   = vecs[i].head;
            commit_mem[vecs[i].f] = vecs[i].commit;
            send_req(vecs[i].f, vecs[i].len, x, y, b);
            if (vecs[i].sat) begin
                exp_q.push_back(mk(vecs[i].f, vecs[i].head, vecs[i].len, x, y, b));
                lat = -1;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (out_val) begin lat = cyc - hs_cyc; break; end
                end
                chk($sformatf("latency_v%0d", i), 64'(lat), 64'd4);
                drain($sformatf("notify_v%0d", i), 100, 1'b1);
            end else begin
                expect_quiet($sformatf("unsat_quiet_v%0d", i), 60);
                raise = 17'(vecs[i].len) + 17'd20;
                if (raise > 17'h10000) raise = 17'h10000;
                commit_mem[vecs[i].f] = vecs[i].head + raise;
                exp_q.push_back(mk(vecs[i].f, vecs[i].head, vecs[i].len, x, y, b));
                drain($sformatf("repoll_v%0d", i), 200, 1'b1);
            end
        end
        expect_quiet("vec_no_extra", 20);

        // Fill: 8 unsatisfied requests hold the queue full through ~20 poll rounds
        for (int k = 0; k < 8; k++) begin
            head_mem[8'h10 + 8'(k)] = 17'h0;
            commit_mem[8'h10 + 8'(k)] = 17'h0;
            send_req(8'h10 + 8'(k), 16'h100, 4'(k), 4'(k + 1), 4'(k + 2));
        end
        hi = 0;
        for (int k = 0; k < 850; k++) begin
            @(negedge clk);
            if (req_rdy) hi++;
        end
        chk("fill_rdy_low", 64'(hi), 64'd0);
        expect_quiet("fill_quiet", 1);
        for (int k = 0; k < 8; k++) begin
            commit_mem[8'h10 + 8'(k)] = 17'h100;
            exp_q.push_back(mk(8'h10 + 8'(k), 17'h0, 16'h100, 4'(k), 4'(k + 1), 4'(k + 2)));
        end
        drain("fill_release", 400, 1'b0);
        expect_quiet("fill_no_dup", 60);
        chk("fill_rdy_back", 64'(req_rdy), 64'd1);

        // Backpressure with head response lagging commit by 3 cycles
        h_delay = 3; c_delay = 0; out_mode = 0;
        head_mem[8'h20] = 17'h00100; commit_mem[8'h20] = 17'h00200;
        send_req(8'h20, 16'h80, 4'h1, 4'h2, 4'h3);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_val) begin found = 1'b1; break; end
        end
        chk("bp_val_seen", 64'(found), 64'd1);
        repeat (10) @(negedge clk);
        chk("bp_val_held", 64'(out_val), 64'd1);
        chk("bp_none_while_stalled", 64'(obs_q.size() - obs_rd), 64'd0);
        out_mode = 1;
        exp_q.push_back(mk(8'h20, 17'h00100, 16'h80, 4'h1, 4'h2, 4'h3));
        drain("bp_release", 40, 1'b1);
        expect_quiet("bp_exactly_one", 20);

        // Reset while in RD_WAIT with 5 pending
        h_delay = 12;
        for (int k = 0; k < 5; k++) begin
            head_mem[8'h30 + 8'(k)] = 17'h40;
            commit_mem[8'h30 + 8'(k)] = 17'h40;
            send_req(8'h30 + 8'(k), 16'd8, 4'h4, 4'h5, 4'h6);
        end
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dbg_state == 3'd2) begin found = 1'b1; break; end
        end
        chk("rst_reached_rd_wait", 64'(found), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_vals", 64'({h_req_val, c_req_val, out_val}), 64'd0);
        chk("rst_async_state", 64'(dbg_state), 64'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        obs_rd = obs_q.size();
        for (int k = 0; k < 5; k++) commit_mem[8'h30 + 8'(k)] = 17'h48;
        expect_quiet("rst_late_resp_quiet", 40);
        chk("rst_idle_after", 64'(dbg_state), 64'd0);
        chk("rst_rdy_after", 64'(req_rdy), 64'd1);
        h_delay = 0;
        head_mem[8'h35] = 17'h00500; commit_mem[8'h35] = 17'h00600;
        send_req(8'h35, 16'h20, 4'h7, 4'h8, 4'h9);
        exp_q.push_back(mk(8'h35, 17'h00500, 16'h20, 4'h7, 4'h8, 4'h9));
        drain("rst_first_after", 60, 1'b1);
        expect_quiet("rst_queue_empty", 80);

        // Randomized run against the arrival-order model
        mem_rand = 1'b1; out_mode = 2;
        for (int k = 0; k < 16; k++) begin
            head_mem[8'h40 + 8'(k)] = 17'($urandom);
            case ($urandom_range(0, 3))
                0:       av = 17'h0;
                1:       av = 17'($urandom_range(0, 300));
                2:       av = 17'h10000;
                default: av = 17'($urandom_range(0, 65536));
            endcase
            commit_mem[8'h40 + 8'(k)] = head_mem[8'h40 + 8'(k)] + av;
        end
        n_unsat = 0;
        for (int n = 0; n < 60; n++) begin
            f  = 8'h40 + 8'($urandom_range(0, 15));
            av = commit_mem[f] - head_mem[f];
            if ($urandom_range(0, 3) == 0) len = 16'($urandom_range(0, 65535));
            else begin
                cand = int'(av) + int'($urandom_range(0, 6)) - 3;
                if (cand < 0) cand = 0;
                if (cand > 65535) cand = 65535;
                len = 16'(cand);
            end
            sat = (17'(len) <= av);
            if (!sat && n_unsat >= 3) begin len = 16'd0; sat = 1'b1; end
            x = 4'($urandom); y = 4'($urandom); b = 4'($urandom);
            send_req(f, len, x, y, b);
            if (sat) exp_q.push_back(mk(f, head_mem[f], len, x, y, b));
            else begin
                unsat_q.push_back(mk(f, head_mem[f], len, x, y, b));
                n_unsat++;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain("rand_notify", 3000, 1'b1);
        for (int k = 0; k < 16; k++) commit_mem[8'h40 + 8'(k)] = head_mem[8'h40 + 8'(k)] + 17'h10000;
        foreach (unsat_q[k]) exp_q.push_back(unsat_q[k]);
        drain("rand_release", 3000, 1'b0);
        out_mode = 1;
        expect_quiet("rand_no_extra", 60);

        chk("out_stable_while_stalled", 64'(stab_viol), 64'd0);
        chk("stall_cycles_observed", 64'(stab_checks >= 10), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcp_rx_msg_poller.md
Name: tcp_rx_msg_poller

Overview:
- Sits directly downstream of the RX message NoC input stage.
- Holds application "notify me when N bytes are ready on flow F" requests in a pending queue and polls each flow's head and commit pointers round-robin.
- When a flow has at least N bytes available, emits a notification (flowid, head ptr, len, return address) to the RX message NoC output stage.
- Unsatisfied requests go back to the tail of the queue.

Parameters:
- FLOWID_W, 8, flow ID width
- RX_PAYLOAD_PTR_W, 16, payload buffer index width; pointers carry one extra wrap bit
- DST_X_W, 4, NoC destination x width
- DST_Y_W, 4, NoC destination y width
- DST_FBITS_W, 4, NoC destination fbits width
- PEND_DEPTH, 8, pending-request queue depth (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- noc_if_poller_msg_req_val  in  1  request valid
- noc_if_poller_msg_req_flowid  in  FLOWID_W  flow
- noc_if_poller_msg_req_len  in  RX_PAYLOAD_PTR_W  bytes requested
- noc_if_poller_msg_dst_x / _dst_y / _dst_fbits  in  DST_X_W / DST_Y_W / DST_FBITS_W  reply destination
- poller_noc_if_msg_req_rdy  out  1  request accept
- poller_head_ptr_rd_req_val  out  1  head ptr read valid
- poller_head_ptr_rd_req_addr  out  FLOWID_W  head ptr read flow
- head_ptr_poller_rd_req_rdy  in  1  head ptr read accept
- head_ptr_poller_rd_resp_val  in  1  head ptr response valid
- head_ptr_poller_rd_resp_data  in  RX_PAYLOAD_PTR_W+1  head ptr
- poller_commit_ptr_rd_req_val / _addr, commit_ptr_poller_rd_req_rdy, commit_ptr_poller_rd_resp_val / _data  same shapes as head-ptr group, for the commit pointer
- poller_msg_noc_if_out_val  out  1  notification valid
- poller_msg_noc_if_out_flowid  out  FLOWID_W
- poller_msg_noc_if_out_head_ptr  out  RX_PAYLOAD_PTR_W+1
- poller_msg_noc_if_out_len  out  RX_PAYLOAD_PTR_W
- poller_msg_noc_if_out_dst_x / _dst_y / _dst_fbits  out  destination fields
- noc_if_out_poller_msg_rdy  in  1  notification accept

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high. On reset the queue is emptied, the FSM goes to IDLE, and all val outputs are 0. Data outputs are 0 at reset and don't-care while val=0.
- Queue: FIFO of {flowid, len, dst_x, dst_y, dst_fbits}, PEND_DEPTH entries. At most one write per cycle.
- inflight = 1 from the cycle an entry is popped until it is sent or requeued.
- Upstream accept: poller_noc_if_msg_req_rdy = (count + inflight < PEND_DEPTH) && !requeue_this_cycle. This guarantees a requeue can never fail. The transfer happens on val&&rdy.
- FSM states and transitions:
  - IDLE: if count>0, pop the head into the working register (inflight=1) and go to RD_REQ. A request written this cycle is not popped the same cycle.
  - RD_REQ: assert both rd_req_val with addr=flowid. Each val drops independently once its own rdy is seen. Go to RD_WAIT when both are accepted.
  - RD_WAIT: capture each resp on its resp_val. Responses may arrive in any order and in the same or different cycles. Go to DECIDE when both are held.
  - DECIDE (1 cycle): avail = (commit - head) mod 2^(RX_PAYLOAD_PTR_W+1). If avail >= len (unsigned; len=0 always satisfied), go to SEND. Otherwise go to REQUEUE.
  - SEND: out_val=1 with the working fields and captured head ptr; hold them stable until rdy. On handshake, inflight=0 and go to IDLE.
  - REQUEUE (1 cycle): write the working entry to the tail. Upstream rdy is 0 this cycle. inflight=0, go to IDLE.
- Ordering: requests are served round-robin in arrival order. The same flow may appear multiple times; each entry is independent.
- Latency: with an empty queue, zero-wait memories, and downstream ready, the earliest out_val is 4 cycles after the request handshake (IDLE, RD_REQ, RD_WAIT, DECIDE, then SEND).
- Pointer wrap is handled by the modular subtract on the extra bit. Correctness requires avail <= 2^RX_PAYLOAD_PTR_W.
- Requests with len > 2^RX_PAYLOAD_PTR_W are never satisfied and recirculate indefinitely; upstream must not issue them.
- Reset mid-operation discards all pending and in-flight requests. Memory responses arriving after reset are ignored.

Test Plan:
- Single request flow 3, len 64, head=0x0010, commit=0x0060 -> one notification after 4 cycles: flowid 3, head 0x0010, len 64, dst fields echoed.
- Request len 100, head=0, commit=50 -> requeued and re-polled. Raise commit to 120 -> notification with len 100, head 0.
- Wrap: head=0x1FFF0, commit=0x00010 (W=16) -> avail 0x20; len 32 satisfied, len 33 requeued.
- Fill: 8 requests all unsatisfied -> upstream rdy low once count+inflight=8; no entry lost or duplicated across 20 poll rounds.
- Backpressure: hold noc_if_out_poller_msg_rdy=0 for 10 cycles, with head resp delayed 3 cycles behind commit resp -> outputs stable, exactly one notification on release.
- Assert rst while in RD_WAIT with 5 pending -> all val outputs 0 immediately, queue empty, a late resp_val causes no output.
